pattern_tx: RTL and testbench

Serial bit-stream transmitter that emits a fixed bit pattern a programmed number of times, with a programmable run of filler bits between repetitions. It is the stimulus/source end of the serial pattern link: its data_out drives the data_in of the pattern detector. This gives benches and system tests a deterministic, known-count stream instead of random bits. It reports progress via busy, a done pulse and a running count of patterns sent.

---
 rtl/pattern_tx.sv | 108 ++++++++++
 tb/tb_pattern_tx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: serial transmitter of a fixed bit pattern repeated N times with filler-bit gaps
module pattern_tx #(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter logic FILL_BIT = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [3:0]       gap_len,
    output logic             data_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);
    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, PAT, GAP, DONE} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic [CNT_W-1:0] rem_q, rem_d, sent_q, sent_d;
    logic data_q, data_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            rem_q   <= '0;
            sent_q  <= '0;
            data_q  <= FILL_BIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            rem_q   <= rem_d;
            sent_q  <= sent_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        rem_d   = rem_q;
        sent_d  = sent_q;
        case (state_q)
            IDLE: if (start) begin
                rem_d   = num_patterns;
                gap_d   = gap_len;
                sent_d  = '0;
                idx_d   = TOP;
                state_d = (num_patterns == '0) ? DONE : PAT;
            end
            PAT: if (abort) begin
                state_d = IDLE;
            end else if (idx_q == '0) begin
                // abort takes priority, so a pattern cut on its last bit is not counted
                sent_d  = sent_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                idx_d   = TOP;
                gcnt_d  = gap_q - 4'd1;
                state_d = (rem_q == CNT_W'(1)) ? DONE : (gap_q == '0) ? PAT : GAP;
            end else begin
                idx_d = idx_q - 1'b1;
            end
            GAP: if (abort) begin
                state_d = IDLE;
            end else if (gcnt_q == '0) begin
                state_d = PAT;
            end else begin
                gcnt_d = gcnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are decoded from the next state so they register alongside it
    always_comb begin
        data_d  = (state_d == PAT) ? PATTERN[idx_d] : FILL_BIT;
        valid_d = (state_d == PAT) || (state_d == GAP);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed and randomized bursts checked against an arithmetic stream model
module tb_pattern_tx;
    localparam int PW = 4;
    localparam logic [PW-1:0] PAT = 4'b1011;
    localparam logic FB = 1'b0;
    localparam int CW = 8;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CW-1:0] num_patterns = '0;
    logic [3:0] gap_len = '0;
    logic data_out, valid, busy, done;
    logic [CW-1:0] sent_count;
    int vectors = 0, errors = 0;

    pattern_tx #(.PAT_W(PW), .PATTERN(PAT), .FILL_BIT(FB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_patterns(num_patterns), .gap_len(gap_len),
        .data_out(data_out), .valid(valid), .busy(busy), .done(done),
        .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic d, input logic b,
                             input logic dn, input int s);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".data_out"}, 32'(data_out), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".sent_count"}, 32'(sent_count), 32'(s));
    endtask

    // patterns whose last bit fell strictly before burst cycle t
    function automatic int sent_at(input int t, input int n, input int g);
        int k;
        if (t <= PW) return 0;
        k = (t - PW - 1) / (PW + g) + 1;
        return (k < n) ? k : n;
    endfunction

    // ab: cycle during which abort is held (0 = none); sp: cycle with a stray start (0 = none)
    task automatic run_burst(input int n, input int g, input int ab, input int sp);
        int len, r;
        len = (n > 0) ? n * PW + (n - 1) * g : 0;
        num_patterns = CW'(n);
        gap_len = 4'(g);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num_patterns = CW'($urandom);
        gap_len = 4'($urandom);
        for (int t = 1; t <= len + 2; t++) begin
            if (ab > 0 && ab <= len && t == ab + 1) begin
                abort = 1'b0;
                check_out("aborted", 1'b0, FB, 1'b0, 1'b0, sent_at(ab, n, g));
                @(posedge clk); #1;
                check_out("after_abort", 1'b0, FB, 1'b0, 1'b0, sent_at(ab, n, g));
                return;
            end
            if (t <= len) begin
                r = (t - 1) % (PW + g);
                check_out("bit", 1'b1, (r < PW) ? PAT[PW-1-r] : FB, 1'b1, 1'b0, sent_at(t, n, g));
            end else if (t == len + 1) begin
                check_out("done", 1'b0, FB, 1'b1, 1'b1, n);
            end else begin
                check_out("idle", 1'b0, FB, 1'b0, 1'b0, n);
            end
            abort = (t == ab) && (t <= len + 1);
            start = (t == sp) && (t <= len + 1);
            if (start) num_patterns = CW'($urandom_range(1, 9));
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int n, g, len, ab, sp;
        rst = 1'b0;
        start = 1'b1;
        num_patterns = 8'd3;
        gap_len = 4'd2;
        repeat (2) begin
            @(posedge clk); #1;
            check_out("reset", 1'b0, FB, 1'b0, 1'b0, 0);
        end
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_out("post_reset", 1'b0, FB, 1'b0, 1'b0, 0);

        run_burst(3, 2, 0, 0);
        run_burst(2, 0, 0, 0);
        run_burst(0, 0, 0, 0);
        run_burst(5, 1, 12, 0);
        run_burst(2, 1, 0, 0);
        run_burst(1, 0, 5, 0);
        run_burst(3, 2, 0, 6);

        num_patterns = 8'd4;
        gap_len = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_out("pre_rst_c1", 1'b1, PAT[PW-1], 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_out("mid_reset", 1'b0, FB, 1'b0, 1'b0, 0);
        rst = 1'b1;
        run_burst(1, 0, 0, 0);

        repeat (10) begin
            n = $urandom_range(0, 5);
            g = $urandom_range(0, 4);
            len = (n > 0) ? n * PW + (n - 1) * g : 0;
            ab = (len > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len + 1) : 0;
            sp = $urandom_range(0, len + 1);
            run_burst(n, g, ab, sp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
